// File: rtl/apb_stream_pkg.sv
// Shared definitions for the APB-to-stream bridge: register offsets,
// CTRL/STATUS bit positions and the APB transfer state encoding.
package apb_stream_pkg;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_CTRL   = 4'h8;
    localparam logic [3:0] REG_DROPS  = 4'hC;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_FLUSH_BIT   = 1;
    localparam int STATUS_FULL_BIT  = 9;
    localparam int STATUS_EMPTY_BIT = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a flush that wins over pop.
// Storage is not reset; only pointers and count are.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Full/empty are pre-edge, so a same-cycle pop never rescues a push into a full FIFO.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/apb_stream_bridge.sv
// APB slave that pushes DATA writes into a FIFO drained as a 32-bit stream.
// Every transfer takes one wait state; register effects land on the DONE edge.
module apb_stream_bridge
    import apb_stream_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [31:0]       pwdata_i,
    output logic              pready_o,
    output logic [31:0]       prdata_o,
    output logic              pslverr_o,
    output logic              m_tvalid_o,
    output logic [31:0]       m_tdata_o,
    input  logic              m_tready_i
);
    localparam int CW = $clog2(DEPTH) + 1;

    apb_state_e    state_q, state_d;
    logic          enable_q, enable_d;
    logic [31:0]   drops_q, drops_d;
    logic          in_done;
    logic          addr_ok;
    logic [3:0]    offset;
    logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status_word, rdata;
    logic          slverr;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (psel_i && !penable_i) state_d = WAIT;
            WAIT:    if (!psel_i) state_d = IDLE;
                     else if (penable_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_done  = (state_q == DONE);
        pready_o = in_done;
    end

    assign offset  = paddr_i[3:0];
    assign addr_ok = ((paddr_i >> 4) == '0) && (paddr_i[1:0] == 2'b00);

    always_comb begin
        status_word                   = 32'(fifo_count);
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
    end

    always_comb begin
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        slverr     = 1'b0;
        rdata      = '0;
        enable_d   = enable_q;
        drops_d    = drops_q;
        if (in_done) begin
            if (!addr_ok) begin
                slverr = 1'b1;
            end else begin
                case (offset)
                    REG_DATA: begin
                        if (!pwrite_i) begin
                            slverr = 1'b1;
                        end else if (fifo_full) begin
                            slverr = 1'b1;
                            if (drops_q != 32'hFFFF_FFFF) drops_d = drops_q + 32'd1;
                        end else begin
                            fifo_push = 1'b1;
                        end
                    end
                    REG_STATUS: begin
                        if (pwrite_i) slverr = 1'b1;
                        else          rdata = status_word;
                    end
                    REG_CTRL: begin
                        if (pwrite_i) begin
                            enable_d   = pwdata_i[CTRL_EN_BIT];
                            fifo_flush = pwdata_i[CTRL_FLUSH_BIT];
                        end else begin
                            rdata[CTRL_EN_BIT] = enable_q;
                        end
                    end
                    REG_DROPS: begin
                        if (pwrite_i) slverr = 1'b1;
                        else          rdata = drops_q;
                    end
                    default: slverr = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_q <= 1'b0;
            drops_q  <= '0;
        end else begin
            enable_q <= enable_d;
            drops_q  <= drops_d;
        end
    end

    assign prdata_o  = rdata;
    assign pslverr_o = slverr;

    // Stream handshake: a beat transfers on any edge where m_tvalid_o and m_tready_i are both high;
    // while m_tvalid_o is high and m_tready_i low, the head entry (m_tdata_o) is held unchanged.
    assign m_tvalid_o = enable_q & ~fifo_empty;
    assign fifo_pop   = m_tvalid_o & m_tready_i;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (pwdata_i),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .data_o  (m_tdata_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
